// File: rtl/slave_vc_allocator.sv
// Round-robin (slave, VC) pair allocator with drain control and illegal-release detection.
// Free bitmaps replace free-lists; grants are combinational from registered state.
module slave_vc_allocator #(
  parameter int VCHANNELBITS = 3,
  parameter int NSLAVEBITS   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    allocReq,
  output logic                    allocGnt,
  output logic [NSLAVEBITS-1:0]   allocSlave,
  output logic [VCHANNELBITS-1:0] allocVirC,
  input  logic                    releaseEn,
  input  logic [NSLAVEBITS-1:0]   releaseSlave,
  input  logic [VCHANNELBITS-1:0] releaseVirC,
  output logic [NSLAVEBITS:0]     busyCount,
  output logic                    idle,
  output logic                    error
);

  localparam int VCHANNELS = 1 << VCHANNELBITS;
  localparam int NSLAVES   = 1 << NSLAVEBITS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q;
  logic                    idle_q;
  logic                    error_q;
  logic [NSLAVES-1:0]      slave_free_q, slave_free_d;
  logic [VCHANNELS-1:0]    vc_free_q, vc_free_d;
  logic [NSLAVEBITS-1:0]   slave_ptr_q, slave_pick;
  logic [VCHANNELBITS-1:0] vc_ptr_q, vc_pick;
  logic [NSLAVEBITS:0]     busy_q, busy_d;
  logic                    rel_ok, rel_bad;

  // Scan from the pointer; iterating offsets high-to-low lets the nearest free index win.
  always_comb begin
    slave_pick = slave_ptr_q;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (slave_free_q[slave_ptr_q + NSLAVEBITS'(i)])
        slave_pick = slave_ptr_q + NSLAVEBITS'(i);
    end
  end

  always_comb begin
    vc_pick = vc_ptr_q;
    for (int i = VCHANNELS - 1; i >= 0; i--) begin
      if (vc_free_q[vc_ptr_q + VCHANNELBITS'(i)])
        vc_pick = vc_ptr_q + VCHANNELBITS'(i);
    end
  end

  assign allocGnt   = allocReq && (state_q == RUN) && (|slave_free_q) && (|vc_free_q);
  assign allocSlave = slave_pick;
  assign allocVirC  = vc_pick;

  assign rel_ok  = releaseEn && !slave_free_q[releaseSlave] && !vc_free_q[releaseVirC];
  assign rel_bad = releaseEn && !rel_ok;

  // A grant only clears free bits and a legal release only sets busy ones, so they never collide.
  for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_slave_bits
    assign slave_free_d[gi] = (slave_free_q[gi] && !(allocGnt && slave_pick == NSLAVEBITS'(gi)))
                              || (rel_ok && releaseSlave == NSLAVEBITS'(gi));
  end

  for (genvar gi = 0; gi < VCHANNELS; gi++) begin : g_vc_bits
    assign vc_free_d[gi] = (vc_free_q[gi] && !(allocGnt && vc_pick == VCHANNELBITS'(gi)))
                           || (rel_ok && releaseVirC == VCHANNELBITS'(gi));
  end

  always_comb begin
    busy_d = busy_q;
    case ({allocGnt, rel_ok})
      2'b10:   busy_d = busy_q + (NSLAVEBITS+1)'(1);
      2'b01:   busy_d = busy_q - (NSLAVEBITS+1)'(1);
      default: busy_d = busy_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idle_q       <= 1'b1;
      error_q      <= 1'b0;
      slave_free_q <= '1;
      vc_free_q    <= '1;
      slave_ptr_q  <= '0;
      vc_ptr_q     <= '0;
      busy_q       <= '0;
    end else begin
      slave_free_q <= slave_free_d;
      vc_free_q    <= vc_free_d;
      busy_q       <= busy_d;
      if (allocGnt) begin
        slave_ptr_q <= slave_pick + NSLAVEBITS'(1);
        vc_ptr_q    <= vc_pick + VCHANNELBITS'(1);
      end
      if (rel_bad)
        error_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= RUN;
            idle_q  <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= (busy_d == '0) ? IDLE : DRAIN;
            idle_q  <= (busy_d == '0);
          end
        end
        DRAIN: begin
          if (busy_d == '0) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busyCount = busy_q;
  assign idle      = idle_q;
  assign error     = error_q;

endmodule

// File: tb/tb_slave_vc_allocator.sv
// Vector table plus scoreboard queue for slave_vc_allocator; async reset checked by hand.
module tb_slave_vc_allocator;

  logic       clk = 1'b0;
  logic       rst, enable, allocReq, releaseEn;
  logic [1:0] releaseSlave;
  logic [2:0] releaseVirC;
  logic       allocGnt, idle, error;
  logic [1:0] allocSlave;
  logic [2:0] allocVirC;
  logic [2:0] busyCount;

  slave_vc_allocator dut (
    .clk(clk), .rst(rst), .enable(enable), .allocReq(allocReq),
    .allocGnt(allocGnt), .allocSlave(allocSlave), .allocVirC(allocVirC),
    .releaseEn(releaseEn), .releaseSlave(releaseSlave), .releaseVirC(releaseVirC),
    .busyCount(busyCount), .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, req, rel;
    int   rs, rv;
    logic gnt, chk_sv;
    int   s, v, busy;
    logic idl, err;
  } vec_t;

  typedef struct {
    logic gnt, chk_sv;
    int   s, v, busy;
    logic idl, err;
  } exp_t;

  vec_t tbl[23];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic en, logic req, logic rel, int rs, int rv,
                              logic gnt, logic chk, int s, int v, int busy, logic idl, logic err);
    vec_t t;
    t.rst = r; t.en = en; t.req = req; t.rel = rel; t.rs = rs; t.rv = rv;
    t.gnt = gnt; t.chk_sv = chk; t.s = s; t.v = v; t.busy = busy; t.idl = idl; t.err = err;
    return t;
  endfunction

  task automatic cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic en, logic req, logic rel, int rs, int rv);
    rst = r; enable = en; allocReq = req; releaseEn = rel;
    releaseSlave = 2'(rs); releaseVirC = 3'(rv);
  endtask

  task automatic push(logic gnt, logic chk, int s, int v, int busy, logic idl, logic err);
    exp_t e;
    e.gnt = gnt; e.chk_sv = chk; e.s = s; e.v = v; e.busy = busy; e.idl = idl; e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    cmp({tag, " allocGnt"}, int'(allocGnt), int'(e.gnt));
    cmp({tag, " busyCount"}, int'(busyCount), e.busy);
    cmp({tag, " idle"}, int'(idle), int'(e.idl));
    cmp({tag, " error"}, int'(error), int'(e.err));
    if (e.chk_sv) begin
      cmp({tag, " allocSlave"}, int'(allocSlave), e.s);
      cmp({tag, " allocVirC"}, int'(allocVirC), e.v);
    end
    $display("%s: gnt=%0b slave=%0d vc=%0d busy=%0d idle=%0b err=%0b",
             tag, allocGnt, allocSlave, allocVirC, busyCount, idle, error);
  endtask

  initial begin
    //              rst en req rel rs rv  gnt chk s  v  busy idle err
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 0,  1, 1, 1, 1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0,  1, 1, 2, 2, 2, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0,  1, 1, 3, 3, 3, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 4, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 4, 0, 0);
    tbl[8]  = mk(0, 1, 0, 1, 2, 2,  0, 0, 0, 0, 4, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0,  1, 1, 2, 4, 3, 0, 0);
    tbl[10] = mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 0, 4, 0, 0);
    tbl[11] = mk(0, 1, 1, 0, 0, 0,  1, 1, 1, 5, 3, 0, 0);
    tbl[12] = mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 4, 0, 0);
    tbl[13] = mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 3, 0, 0);
    tbl[14] = mk(0, 1, 0, 1, 3, 3,  0, 0, 0, 0, 3, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1);
    tbl[16] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1);
    tbl[17] = mk(0, 1, 1, 1, 1, 5,  0, 0, 0, 0, 2, 0, 1);
    tbl[18] = mk(0, 1, 1, 1, 2, 4,  0, 0, 0, 0, 1, 0, 1);
    tbl[19] = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[20] = mk(0, 1, 1, 0, 0, 0,  1, 1, 2, 6, 0, 0, 1);
    tbl[21] = mk(0, 1, 1, 0, 0, 0,  1, 1, 3, 7, 1, 0, 1);
    tbl[22] = mk(0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 2, 0, 1);

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].rel, tbl[i].rs, tbl[i].rv);
      push(tbl[i].gnt, tbl[i].chk_sv, tbl[i].s, tbl[i].v, tbl[i].busy, tbl[i].idl, tbl[i].err);
      #1;
      check_out($sformatf("vec%0d", i));
    end

    // Mid-RUN async reset with 3 outstanding and error set.
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0);
    push(1, 1, 1, 1, 3, 0, 1);
    #1;
    check_out("pre_reset");
    #1;
    rst = 1'b1;
    push(0, 1, 0, 0, 0, 1, 0);
    #1;
    check_out("async_reset");

    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 1, 0);
    #1;
    check_out("post_reset_idle");

    @(negedge clk);
    push(1, 1, 0, 0, 0, 0, 0);
    #1;
    check_out("post_reset_grant");

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    cmp("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
